// File: rtl/md_pkg.sv
// md_pkg: shared encodings, FSM state type and default latencies for the MIPS multiply/divide sequencer.
package md_pkg;
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;
  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV} md_state_t;
  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
endpackage

// File: rtl/md_compute.sv
// md_compute: combinational mult/multu/div/divu producing {hi, lo}; divide by zero yields 0.
module md_compute
  import md_pkg::*;
(
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] res_o
);
  logic        sgn, is_div, a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, q, r;
  logic [63:0] a_ext, b_ext, prod;
  assign sgn    = op_i == MD_MULT || op_i == MD_DIV;
  assign is_div = op_i == MD_DIV || op_i == MD_DIVU;
  assign a_ext  = {{32{sgn & a_i[31]}}, a_i};
  assign b_ext  = {{32{sgn & b_i[31]}}, b_i};
  assign prod   = a_ext * b_ext;
  // Divide on magnitudes so 0x80000000 / -1 needs no special case.
  assign a_neg  = sgn & a_i[31];
  assign b_neg  = sgn & b_i[31];
  assign a_mag  = a_neg ? -a_i : a_i;
  assign b_mag  = b_neg ? -b_i : b_i;
  assign q_mag  = b_mag == '0 ? '0 : a_mag / b_mag;
  assign r_mag  = b_mag == '0 ? '0 : a_mag % b_mag;
  assign q      = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign r      = a_neg ? -r_mag : r_mag;
  assign res_o  = is_div ? {r, q} : prod;
endmodule

// File: rtl/md_sequencer.sv
// md_sequencer: HI/LO owner with multi-cycle mult/div latency, commit on countdown end, and D-stage stall.
module md_sequencer
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        d_is_md,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  localparam int CW = $clog2((MULT_CYCLES > DIV_CYCLES ? MULT_CYCLES : DIV_CYCLES) + 1);
  md_state_t   state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] p_q, p_d, res;
  logic        dz_q, dz_d, arith;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  md_compute u_compute (.op_i(md_op), .a_i(rs_val), .b_i(rt_val), .res_o(res));
  assign arith = start && md_op <= MD_DIVU;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    if (state_q == S_IDLE) begin
      state_d = arith ? (md_op <= MD_MULTU ? S_MULT : S_DIV) : S_IDLE;
      cnt_d   = arith ? (md_op <= MD_MULTU ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES)) : cnt_q;
      p_d     = arith ? res : p_q;
      dz_d    = arith ? (md_op >= MD_DIV && rt_val == '0) : dz_q;
      hi_d    = start && md_op == MD_MTHI ? rs_val : hi_q;
      lo_d    = start && md_op == MD_MTLO ? rs_val : lo_q;
    end else begin
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d = S_IDLE;
        // A zero divisor burns the full latency but leaves HI/LO untouched.
        hi_d    = dz_q ? hi_q : p_q[63:32];
        lo_d    = dz_q ? lo_q : p_q[31:0];
      end
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
  assign busy     = state_q != S_IDLE;
  assign stall_md = d_is_md & (busy | (start & (md_op < 3'd4)));
  assign hi       = hi_q;
  assign lo       = lo_q;
endmodule
